timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 185 ++++++++++++++++++
 tb/tb_timer_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_bank
// Brief    : Memory-mapped free-running counter with NUM_CH compare/interrupt
//            channels. The optional prescaler is built when the macro
//            TIMER_BANK_PRESCALE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic [31:0]       data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       cycle,
    output logic              TimerAddress,
    output logic [NUM_CH-1:0] TimerInterrupt,
    output logic              TimerInterruptAny
);

    localparam logic [29:0] c_NUM_WORDS = 30'(4 * (NUM_CH + 1));

    logic [31:0]              w_off;
    logic [5:0]               w_word;
    logic                     w_wr;
    logic                     w_tick;
    logic [31:0]              w_presc_rd;
    logic [31:0]              w_rd;
    logic [NUM_CH-1:0][31:0]  w_ch_rd;
    logic [WIDTH-1:0]         r_count_q;
    logic [WIDTH-1:0]         w_count_d;

    // Unsigned subtraction makes addresses below the base wrap far outside the window.
    assign w_off        = address - BASE_ADDR;
    assign TimerAddress = (w_off[1:0] == 2'b00) && (w_off[31:2] < c_NUM_WORDS);
    assign w_word       = w_off[7:2];
    assign w_wr         = MemWrite && TimerAddress;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [15:0] r_presc_q;
    logic [15:0] w_presc_d;
    logic [15:0] r_pcnt_q;
    logic [15:0] w_pcnt_d;

    always_comb begin
        w_tick    = (r_pcnt_q == r_presc_q);
        w_presc_d = r_presc_q;
        w_pcnt_d  = w_tick ? 16'd0 : r_pcnt_q + 16'd1;
        if (w_wr && (w_word == 6'd1)) begin
            w_presc_d = data[15:0];
            w_pcnt_d  = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q <= 16'd0;
            r_pcnt_q  <= 16'd0;
        end else begin
            r_presc_q <= w_presc_d;
            r_pcnt_q  <= w_pcnt_d;
        end
    end

    assign w_presc_rd = {16'd0, r_presc_q};
`else
    assign w_tick     = 1'b1;
    assign w_presc_rd = 32'd0;
`endif

    // A software load of COUNT replaces the increment for that edge.
    always_comb begin
        w_count_d = r_count_q;
        if (w_wr && (w_word == 6'd0)) begin
            w_count_d = data[WIDTH-1:0];
        end else if (w_tick) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [3:0] c_GRP = 4'(gi + 1);

        logic [WIDTH-1:0] r_cmp_q;
        logic [WIDTH-1:0] w_cmp_d;
        logic [WIDTH-1:0] r_per_q;
        logic [WIDTH-1:0] w_per_d;
        logic [2:0]       r_ctrl_q;
        logic [2:0]       w_ctrl_d;
        logic             r_pend_q;
        logic             w_pend_d;
        logic             w_sel;
        logic             w_match;
        logic [31:0]      w_ch_val;

        assign w_sel   = (w_word[5:2] == c_GRP);
        assign w_match = w_tick && r_ctrl_q[0] && (r_count_q == r_cmp_q);

        // Software writes take priority over reload and one-shot disable;
        // a match still sets PENDING even against a same-cycle ack.
        always_comb begin
            w_cmp_d  = r_cmp_q;
            w_per_d  = r_per_q;
            w_ctrl_d = r_ctrl_q;
            w_pend_d = r_pend_q;
            if (w_wr && w_sel && (w_word[1:0] == 2'd0)) begin
                w_cmp_d = data[WIDTH-1:0];
            end else if (w_match && r_ctrl_q[2]) begin
                w_cmp_d = r_cmp_q + r_per_q;
            end
            if (w_wr && w_sel && (w_word[1:0] == 2'd1)) begin
                w_per_d = data[WIDTH-1:0];
            end
            if (w_wr && w_sel && (w_word[1:0] == 2'd2)) begin
                w_ctrl_d = data[2:0];
            end else if (w_match && !r_ctrl_q[2]) begin
                w_ctrl_d = {r_ctrl_q[2:1], 1'b0};
            end
            if (w_match) begin
                w_pend_d = 1'b1;
            end else if (w_wr && w_sel && (w_word[1:0] == 2'd3) && data[0]) begin
                w_pend_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cmp_q  <= '0;
                r_per_q  <= '0;
                r_ctrl_q <= 3'd0;
                r_pend_q <= 1'b0;
            end else begin
                r_cmp_q  <= w_cmp_d;
                r_per_q  <= w_per_d;
                r_ctrl_q <= w_ctrl_d;
                r_pend_q <= w_pend_d;
            end
        end

        always_comb begin
            w_ch_val = 32'd0;
            if (w_sel) begin
                case (w_word[1:0])
                    2'd0:    w_ch_val = 32'(r_cmp_q);
                    2'd1:    w_ch_val = 32'(r_per_q);
                    2'd2:    w_ch_val = {29'd0, r_ctrl_q};
                    default: w_ch_val = {31'd0, r_pend_q};
                endcase
            end
        end

        assign w_ch_rd[gi]        = w_ch_val;
        assign TimerInterrupt[gi] = r_pend_q & r_ctrl_q[1];
    end

    always_comb begin
        w_rd = 32'd0;
        case (w_word)
            6'd0:    w_rd = 32'(r_count_q);
            6'd1:    w_rd = w_presc_rd;
            default: w_rd = 32'd0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            w_rd = w_rd | w_ch_rd[i];
        end
        cycle = (MemRead && TimerAddress) ? w_rd : 32'd0;
    end

    assign TimerInterruptAny = |TimerInterrupt;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_bank
// Brief    : Directed self-checking bench for timer_bank (NUM_CH=4, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    localparam logic [31:0] c_BASE = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'd0;
    logic [31:0] data = 32'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] cycle;
    logic        TimerAddress;
    logic [3:0]  TimerInterrupt;
    logic        TimerInterruptAny;

    int total = 0;
    int bad   = 0;

    timer_bank #(
        .NUM_CH    (4),
        .WIDTH     (8),
        .BASE_ADDR (c_BASE)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .data              (data),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .cycle             (cycle),
        .TimerAddress      (TimerAddress),
        .TimerInterrupt    (TimerInterrupt),
        .TimerInterruptAny (TimerInterruptAny)
    );

    always #5 clk = ~clk;

    // Register address: group 0 is global, group c+1 is channel c.
    function automatic logic [31:0] ra(input int g, input int k);
        return c_BASE + 32'(16 * g + 4 * k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address  = a;
        data     = d;
        MemWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        address = a;
        MemRead = 1'b1;
        #1;
        v       = cycle;
        MemRead = 1'b0;
        chk(tag, v, exp);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_irq", {28'd0, TimerInterrupt}, 32'd0);
        chk("rst_any", {31'd0, TimerInterruptAny}, 32'd0);
        rchk("rst_count", ra(0, 0), 32'd0);
        rchk("rst_presc", ra(0, 1), 32'd0);
        reset = 1'b0;

        // one-shot channel 0
        wr(ra(0, 0), 32'd0);
        wr(ra(1, 0), 32'd10);
        wr(ra(1, 2), 32'd3);
        repeat (8) @(negedge clk);
        chk("os_pre_irq", {28'd0, TimerInterrupt}, 32'd0);
        rchk("os_pre_count", ra(0, 0), 32'd10);
        @(negedge clk);
        chk("os_irq", {28'd0, TimerInterrupt}, 32'h1);
        chk("os_any", {31'd0, TimerInterruptAny}, 32'd1);
        rchk("os_count", ra(0, 0), 32'd11);
        rchk("os_ctrl", ra(1, 2), 32'd2);
        rchk("os_status", ra(1, 3), 32'd1);
        wr(ra(1, 3), 32'd0);
        chk("ack0_noclr", {28'd0, TimerInterrupt}, 32'h1);
        wr(ra(1, 3), 32'd1);
        chk("ack_clr", {28'd0, TimerInterrupt}, 32'd0);
        chk("ack_any", {31'd0, TimerInterruptAny}, 32'd0);

        // periodic channel 1: fires at COUNT 5, 13, 21
        wr(ra(0, 0), 32'd0);
        wr(ra(2, 0), 32'd5);
        wr(ra(2, 1), 32'd8);
        wr(ra(2, 2), 32'd7);
        repeat (2) @(negedge clk);
        chk("per_pre", {28'd0, TimerInterrupt}, 32'd0);
        @(negedge clk);
        chk("per_f1", {28'd0, TimerInterrupt}, 32'h2);
        rchk("per_cmp1", ra(2, 0), 32'd13);
        wr(ra(2, 3), 32'd1);
        chk("per_ack1", {28'd0, TimerInterrupt}, 32'd0);
        repeat (6) @(negedge clk);
        chk("per_pre2", {28'd0, TimerInterrupt}, 32'd0);
        @(negedge clk);
        chk("per_f2", {28'd0, TimerInterrupt}, 32'h2);
        rchk("per_cmp2", ra(2, 0), 32'd21);
        wr(ra(2, 3), 32'd1);
        repeat (7) @(negedge clk);
        chk("per_f3", {28'd0, TimerInterrupt}, 32'h2);
        rchk("per_cmp3", ra(2, 0), 32'd29);
        wr(ra(2, 2), 32'd0);
        wr(ra(2, 3), 32'd1);
        chk("per_off", {28'd0, TimerInterrupt}, 32'd0);

        // wrap on channel 2
        wr(ra(3, 0), 32'd0);
        wr(ra(3, 2), 32'd3);
        wr(ra(0, 0), 32'd255);
        rchk("wrap_255", ra(0, 0), 32'd255);
        chk("wrap_irq0", {28'd0, TimerInterrupt}, 32'd0);
        @(negedge clk);
        rchk("wrap_zero", ra(0, 0), 32'd0);
        chk("wrap_irq1", {28'd0, TimerInterrupt}, 32'd0);
        @(negedge clk);
        chk("wrap_fire", {28'd0, TimerInterrupt}, 32'h4);
        rchk("wrap_ctrl", ra(3, 2), 32'd2);
        wr(ra(3, 3), 32'd1);

        // ack on the match edge, PERIOD=0, IE masking
        wr(ra(0, 0), 32'd0);
        wr(ra(1, 0), 32'd5);
        wr(ra(1, 2), 32'd7);
        repeat (3) @(negedge clk);
        chk("sim_pre", {28'd0, TimerInterrupt}, 32'd0);
        wr(ra(1, 3), 32'd1);
        chk("sim_setwins", {28'd0, TimerInterrupt}, 32'h1);
        rchk("sim_cmp_p0", ra(1, 0), 32'd5);
        rchk("sim_ctrl", ra(1, 2), 32'd7);
        wr(ra(1, 3), 32'd1);
        chk("sim_ack", {28'd0, TimerInterrupt}, 32'd0);
        rchk("sim_stat0", ra(1, 3), 32'd0);
        wr(ra(0, 0), 32'd4);
        repeat (2) @(negedge clk);
        chk("mask_fire", {28'd0, TimerInterrupt}, 32'h1);
        wr(ra(1, 2), 32'd5);
        chk("mask_irq", {28'd0, TimerInterrupt}, 32'd0);
        chk("mask_any", {31'd0, TimerInterruptAny}, 32'd0);
        rchk("mask_stat", ra(1, 3), 32'd1);

        // CTRL write on a one-shot match edge: write wins, PENDING still set
        wr(ra(4, 0), 32'd10);
        wr(ra(4, 2), 32'd3);
        @(negedge clk);
        wr(ra(4, 2), 32'd3);
        chk("cw_irq", {28'd0, TimerInterrupt}, 32'h8);
        rchk("cw_ctrl", ra(4, 2), 32'd3);
        rchk("cw_count", ra(0, 0), 32'd11);

        // window boundaries
        address = c_BASE + 32'd80;
        MemRead = 1'b1;
        #1;
        chk("oob_ta", {31'd0, TimerAddress}, 32'd0);
        chk("oob_cyc", cycle, 32'd0);
        address = c_BASE + 32'd2;
        #1;
        chk("mis_ta", {31'd0, TimerAddress}, 32'd0);
        chk("mis_cyc", cycle, 32'd0);
        address = c_BASE - 32'd4;
        #1;
        chk("low_ta", {31'd0, TimerAddress}, 32'd0);
        MemRead = 1'b0;
        @(negedge clk);
        address = c_BASE + 32'd76;
        #1;
        chk("last_ta", {31'd0, TimerAddress}, 32'd1);
        chk("noread_cyc", cycle, 32'd0);
        rchk("last_rd", c_BASE + 32'd76, 32'd1);
        wr(c_BASE + 32'd2, 32'd200);
        wr(c_BASE + 32'd80, 32'd0);
        rchk("oob_nowr", ra(0, 0), 32'd14);
        wr(ra(0, 2), 32'hFF);
        rchk("rsvd_rd", ra(0, 2), 32'd0);

        // reset mid-run with a concurrent write
        address  = ra(1, 0);
        data     = 32'd99;
        MemWrite = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        chk("mr_irq", {28'd0, TimerInterrupt}, 32'd0);
        rchk("mr_count", ra(0, 0), 32'd0);
        rchk("mr_cmp0", ra(1, 0), 32'd0);
        rchk("mr_ctrl3", ra(4, 2), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("mr_quiet", {28'd0, TimerInterrupt}, 32'd0);
        rchk("mr_run", ra(0, 0), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
